fifo_wr_ctrl_pkt: RTL
=====================

# fifo_wr_ctrl_pkt

Write-side controller for the Ethernet datapath's dual-clock frame FIFO; it replaces the plain write controller where whole-frame semantics are needed. It runs entirely in the write clock domain and brings the reader's Gray pointer in through a parametrised synchronizer. It writes frame words speculatively and publishes its Gray pointer to the reader only when a good frame completes, so the reader never sees partial frames. Bad, aborted or overflowing frames are rewound and counted. It also provides almost-full and fill-level status.

## Interface
- AWIDTH, 4: address width; FIFO depth = 2^AWIDTH; pointers are AWIDTH+1 bits.
- SYNC_STAGES, 2: flop stages on rgray, legal range 2..4.
- AFULL_THRESH, 2^AWIDTH-2: wafull asserts when level ≥ this value.
- PKT_MODE, 1: 1 = commit per frame; 0 = commit every write (legacy behaviour), wlast/wbad ignored.

- wclk  in  1  write clock; the only clock in the block.
- arst_n  in  1  reset, synchronous, active-low, sampled on the wclk rising edge.
- wdv  in  1  write data valid for this cycle.
- wlast  in  1  qualifies wdv: last word of the frame.
- wbad  in  1  qualifies wdv&&wlast: frame is bad (FCS/err), discard it.
- rgray  in  AWIDTH+1  reader Gray pointer from the read domain (asynchronous).
- wgray  out  AWIDTH+1  committed write pointer, Gray, to the reader.
- waddr  out  AWIDTH  RAM write address = tentative pointer low bits.
- wen  out  1  RAM write enable.
- wfull  out  1  no free slot for the tentative pointer.
- wafull  out  1  almost full.
- wlevel  out  AWIDTH+1  tentative pointer minus synchronized read pointer (0..2^AWIDTH).
- frame_drop  out  1  one-cycle pulse when a frame is rewound.
- drop_cnt  out  16  count of dropped frames, saturates at 0xFFFF.

## Operation
- Pointers:
  - tptr (tentative, binary) advances on wen.
  - cptr (committed, binary) loads tptr_next on commit.
  - wgray = registered bin2gray(cptr).
- rgray passes through SYNC_STAGES flops and is then gray-to-binary converted to rbin.
- wen = wdv && !wfull && state != DISCARD (combinational).
- tptr_next:
  - cptr on rewind;
  - tptr+1 on wen;
  - otherwise tptr.
  - The increment wraps modulo 2^(AWIDTH+1).
- Registered status, all derived from tptr_next and rbin:
  - wfull <= (rbin == {~tptr_next[AWIDTH], tptr_next[AWIDTH-1:0]}).
  - wlevel <= tptr_next − rbin, computed modulo 2^(AWIDTH+1).
  - wafull <= (tptr_next − rbin) ≥ AFULL_THRESH.
- FSM when PKT_MODE=1. States are IDLE, FRAME and DISCARD.
  - IDLE / FRAME, cycle with wen:
    - wlast=0: go to FRAME.
    - wlast=1, wbad=0: commit (cptr <= tptr+1) and go to IDLE.
    - wlast=1, wbad=1: rewind (tptr <= cptr), pulse frame_drop, go to IDLE.
  - IDLE / FRAME, cycle with wdv && wfull (overflow):
    - wlast=0: no write; go to DISCARD.
    - wlast=1: rewind, pulse frame_drop, go to IDLE.
  - DISCARD: all words are ignored, with no writes. On wdv&&wlast: rewind, pulse frame_drop, go to IDLE.
- drop_cnt increments on every frame_drop until it reaches 0xFFFF.
- PKT_MODE=0:
  - cptr tracks tptr_next every cycle.
  - The FSM stays in IDLE.
  - frame_drop is never asserted; a write while full is silently ignored.
- A frame larger than the depth fills the FIFO, overflows, and is dropped. Nothing is ever committed for it.
- Reset: while arst_n=0 at a clock edge, all of the following are cleared to 0 and the state goes to IDLE:
  - tptr, cptr, the sync flops, wgray, wfull, wafull, wlevel, frame_drop, drop_cnt.
  - A frame in progress is lost; the reader sees wgray=0.
  - wen and waddr follow combinationally (wen=0 if wdv=0).

## Timing
- Write is zero-latency: the RAM writes at the edge where wen=1, at waddr=tptr.
- Commit → wgray: wgray changes at the edge after the edge at which the last word is written.
- wfull, wafull and wlevel reflect a write or rewind one edge after it.
- A reader advance reaches rbin after SYNC_STAGES edges, and reaches wfull/wlevel one edge later.
- The commit/rewind decision uses wlast/wbad sampled in the same cycle as the final wdv.
- wlast/wbad without wdv are ignored.
- Rewind while the reader is draining: level is recomputed from cptr in the same edge. wfull deasserts unless cptr itself is full.
- Simultaneous write and reader advance: the write counts and the read is seen later via the sync. The FIFO is never overrun.

## Test plan
All scenarios use AWIDTH=3 (depth 8), SYNC_STAGES=2 and AFULL_THRESH=6, with rgray held at 0 unless stated.
- Good frame: 3 words, wlast on the 3rd, wbad=0.
  - waddr takes 0,1,2.
  - wgray stays 0 until 1 edge after the 3rd write, then becomes 3'b0010 (bin 3).
  - wlevel=3 and drop_cnt=0.
- Bad frame after the good frame: 2 words, wbad=1 on the last.
  - frame_drop pulses once.
  - tptr returns to 3, wlevel=3, wgray stays bin 3, drop_cnt=1.
  - The next good frame writes starting at waddr 3.
- Overflow:
  - A 10-word frame: 8 writes, after which wfull=1 and wafull=1. Word 9 moves the FSM to DISCARD.
  - Word 10, with wlast, rewinds: frame_drop=1, wlevel=0, wfull=0, and wgray never changes.
- Full from the reader side, then release:
  - Commit 8 words one frame at a time; wfull=1 and wgray=bin 8 (Gray 01100).
  - Drive rgray=Gray(2). wfull clears exactly 3 edges later and wlevel=6.
  - Then write 2 more words with wrap: waddr takes 0,1.
- PKT_MODE=0:
  - 5 single writes with wlast=0 advance wgray each cycle: bin 1..5 appear 1 edge after each write.
  - wdv while full leaves waddr unchanged and never pulses frame_drop.
- Reset mid-frame:
  - Assert arst_n=0 for 1 cycle after 2 words of a frame.
  - Every output is 0 and the state is IDLE.
  - A new frame starts at waddr 0, and drop_cnt does not count the lost frame.

Source files
------------

// File: rtl/fifo_wr_ctrl_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_ctrl_pkt
//  Description : Write-side controller for a dual-clock frame FIFO. Words are
//                written speculatively at a tentative pointer. The Gray
//                pointer seen by the reader advances only when a good frame
//                completes. Bad, aborted or overflowing frames are rewound
//                and counted. Also provides full, almost-full and fill-level
//                status, all registered in the write clock domain.
//  Ports       : wclk_i        write clock
//                arst_n_i      synchronous active-low reset
//                wdv_i         write data valid
//                wlast_i       last word of frame (qualifies wdv_i)
//                wbad_i        frame is bad (qualifies wdv_i && wlast_i)
//                rgray_i       reader Gray pointer (asynchronous)
//                wgray_o       committed write pointer, Gray, to reader
//                waddr_o       RAM write address
//                wen_o         RAM write enable
//                wfull_o       no free slot for the tentative pointer
//                wafull_o      almost full
//                wlevel_o      tentative fill level
//                frame_drop_o  one-cycle pulse on frame rewind
//                drop_cnt_o    saturating count of dropped frames
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wr_ctrl_pkt #(
    parameter int AWIDTH       = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = (1 << AWIDTH) - 2,
    parameter int PKT_MODE     = 1
) (
    input  logic              wclk_i,
    input  logic              arst_n_i,
    input  logic              wdv_i,
    input  logic              wlast_i,
    input  logic              wbad_i,
    input  logic [AWIDTH:0]   rgray_i,
    output logic [AWIDTH:0]   wgray_o,
    output logic [AWIDTH-1:0] waddr_o,
    output logic              wen_o,
    output logic              wfull_o,
    output logic              wafull_o,
    output logic [AWIDTH:0]   wlevel_o,
    output logic              frame_drop_o,
    output logic [15:0]       drop_cnt_o
);

    localparam logic [AWIDTH:0] c_afull_thresh = AFULL_THRESH[AWIDTH:0];
    localparam logic [AWIDTH:0] c_one          = {{AWIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FRAME   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [AWIDTH:0]                      tptr_q, tptr_d;
    logic [AWIDTH:0]                      cptr_q, cptr_d;
    logic [SYNC_STAGES-1:0][AWIDTH:0]     sync_q;
    logic [AWIDTH:0]                      wgray_q;
    logic                                 wfull_q;
    logic                                 wafull_q;
    logic [AWIDTH:0]                      wlevel_q;
    logic                                 frame_drop_q;
    logic [15:0]                          drop_cnt_q;

    logic                                 w_wen;
    logic                                 w_ovf;
    logic                                 w_rewind;
    logic                                 w_commit;
    logic [AWIDTH:0]                      w_rbin;
    logic [AWIDTH:0]                      w_level;

    function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
        logic [AWIDTH:0] b;
        b[AWIDTH] = g[AWIDTH];
        for (int i = AWIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_rbin = gray2bin(sync_q[SYNC_STAGES-1]);

    // Full is a registered flag, so a write can never be issued into a slot
    // the reader has not provably freed; read frees arrive late, never early.
    assign w_wen = wdv_i && !wfull_q && (state_q != S_DISCARD);
    assign w_ovf = wdv_i &&  wfull_q && (state_q != S_DISCARD);

    always_comb begin
        w_rewind = 1'b0;
        w_commit = 1'b0;
        state_d  = state_q;
        if (PKT_MODE != 0) begin
            case (state_q)
                S_IDLE, S_FRAME: begin
                    if (w_wen) begin
                        if (!wlast_i) begin
                            state_d = S_FRAME;
                        end else if (wbad_i) begin
                            w_rewind = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            w_commit = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end else if (w_ovf) begin
                        if (wlast_i) begin
                            w_rewind = 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            state_d  = S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (wdv_i && wlast_i) begin
                        w_rewind = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        if (w_rewind) begin
            tptr_d = cptr_q;
        end else if (w_wen) begin
            tptr_d = tptr_q + c_one;
        end else begin
            tptr_d = tptr_q;
        end
        // A commit always coincides with a write, so tptr_d is tptr + 1 here.
        cptr_d  = ((PKT_MODE == 0) || w_commit) ? tptr_d : cptr_q;
        w_level = tptr_d - w_rbin;
    end

    always_ff @(posedge wclk_i) begin
        if (!arst_n_i) begin
            state_q      <= S_IDLE;
            tptr_q       <= '0;
            cptr_q       <= '0;
            sync_q       <= '0;
            wgray_q      <= '0;
            wfull_q      <= 1'b0;
            wafull_q     <= 1'b0;
            wlevel_q     <= '0;
            frame_drop_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tptr_q       <= tptr_d;
            cptr_q       <= cptr_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], rgray_i};
            wgray_q      <= cptr_q ^ (cptr_q >> 1);
            wfull_q      <= (w_rbin == {~tptr_d[AWIDTH], tptr_d[AWIDTH-1:0]});
            wafull_q     <= (w_level >= c_afull_thresh);
            wlevel_q     <= w_level;
            frame_drop_q <= w_rewind;
            if (w_rewind && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign wgray_o      = wgray_q;
    assign waddr_o      = tptr_q[AWIDTH-1:0];
    assign wen_o        = w_wen;
    assign wfull_o      = wfull_q;
    assign wafull_o     = wafull_q;
    assign wlevel_o     = wlevel_q;
    assign frame_drop_o = frame_drop_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule
`default_nettype wire
